// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits never overflow.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder built from two half adders and an OR for the carry.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  halfadder u_ha1 (
    .a_i (s1),
    .b_i (cin_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign cout_o = c1 | c2;

endmodule

// File: rtl/serial_adder_halfadder.sv
// One-bit half adder used twice inside the full adder.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first. Handshake: a request is taken when
// i_w_start=1 and o_w_ready=1 at a rising edge; o_r_done pulses one cycle when the result is valid.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_cin,
  output logic             o_w_ready,
  output logic [WIDTH-1:0] o_r_sum,
  output logic             o_r_cout,
  output logic             o_r_done,
  output logic [1:0]       o_w_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  fulladder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; the unused code 2'd3 behaves as IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_RUN:  state_d = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = i_w_start ? ST_RUN : ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_w_ready = (state_q != ST_RUN) && (state_q != ST_DONE);
    o_w_state = state_q;
  end

  // Datapath next values
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    if (state_q == ST_RUN) begin
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_ONE;
      if (last_bit) begin
        cout_d = fa_cout;
        done_d = 1'b1;
      end
    end else if (o_w_ready && i_w_start) begin
      a_sh_d  = i_w_a;
      b_sh_d  = i_w_b;
      carry_d = i_w_cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign o_r_sum  = sum_q;
  assign o_r_cout = cout_q;
  assign o_r_done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed/random traffic and WIDTH=4 exhaustive sweep,
// both checked against a cycle-level transaction model built from the latency and sum rules.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       ready8, cout8, done8;
  logic [7:0] sum8;
  logic [1:0] state8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       ready4, cout4, done4;
  logic [3:0] sum4;
  logic [1:0] state4;

  int n_checks = 0;
  int n_fail   = 0;
  int done4_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start8), .i_w_a(a8), .i_w_b(b8),
    .i_w_cin(cin8), .o_w_ready(ready8), .o_r_sum(sum8), .o_r_cout(cout8),
    .o_r_done(done8), .o_w_state(state8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start4), .i_w_a(a4), .i_w_b(b4),
    .i_w_cin(cin4), .o_w_ready(ready4), .o_r_sum(sum4), .o_r_cout(cout4),
    .o_r_done(done4), .o_w_state(state4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An accepted op is busy for WIDTH+1 edges; done is seen with one edge left.
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  int         busy8 = 0, busy4 = 0;
  logic [8:0] last8 = '0;
  logic [4:0] last4 = '0;
  bit         valid = 0, just_rst = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy8 = 0; busy4 = 0;
      exp8_q.delete(); exp4_q.delete();
      last8 = '0; last4 = '0;
      valid = 1; just_rst = 1;
    end else begin
      just_rst = 0;
      if (busy8 == 0 && start8) begin
        exp8_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        busy8 = 9;
      end else if (busy8 > 0) busy8--;
      if (busy4 == 0 && start4) begin
        exp4_q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        busy4 = 5;
      end else if (busy4 > 0) busy4--;
    end
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  always @(negedge clk) begin
    if (valid) begin
      if (just_rst) begin
        check_eq("rst_sum8", sum8, 0);
        check_eq("rst_cout8", cout8, 0);
        check_eq("rst_done8", done8, 0);
        check_eq("rst_ready8", ready8, 1);
      end
      check_eq("ready8", ready8, busy8 == 0);
      check_eq("done8", done8, busy8 == 1);
      check_eq("ready4", ready4, busy4 == 0);
      check_eq("done4", done4, busy4 == 1);
      if (done4) done4_cnt++;
      if (busy8 == 1) begin
        if (exp8_q.size() == 0) check_eq("q8_empty", 1, 0);
        else begin
          last8 = exp8_q.pop_front();
          check_eq("result8", {cout8, sum8}, last8);
        end
      end else if (busy8 == 0) check_eq("hold8", {cout8, sum8}, last8);
      if (busy4 == 1) begin
        if (exp4_q.size() == 0) check_eq("q4_empty", 1, 0);
        else begin
          last4 = exp4_q.pop_front();
          check_eq("result4", {cout4, sum4}, last4);
        end
      end else if (busy4 == 0) check_eq("hold4", {cout4, sum4}, last4);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk); #2;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    repeat (9) @(posedge clk);
    #2;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(posedge clk); #2;
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #2;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    op8(8'h0F, 8'h01, 1'b0);
    check_eq("tp_0f_01", {cout8, sum8}, 9'h010);
    op8(8'hFF, 8'h01, 1'b0);
    check_eq("tp_ff_01", {cout8, sum8}, 9'h100);
    op8(8'hFF, 8'hFF, 1'b1);
    check_eq("tp_wrap", {cout8, sum8}, 9'h1FF);

    // second request during RUN must be ignored
    @(posedge clk); #2;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #2 a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #2 start8 = 1'b0;
    repeat (9) @(posedge clk);
    #2 check_eq("tp_ignore", {cout8, sum8}, 9'h046);

    // reset in the middle of RUN
    @(posedge clk); #2;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #2 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    op8(8'h01, 8'h02, 1'b0);
    check_eq("tp_after_rst", {cout8, sum8}, 9'h003);

    // start held high with operands changing every cycle
    start8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(posedge clk); #2;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);

    for (int i = 0; i < 20; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));
    repeat (8) @(posedge clk);
    #2;
    check_eq("done4_count", done4_cnt, 512);
    check_eq("drain8", exp8_q.size(), 0);
    check_eq("drain4", exp4_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
